// File: rtl/snitch_data_mem_bist.sv
// TCDM bank-array BIST: parallel pattern write/read-back over all banks.
// Optional SNITCH_DATA_MEM_BIST_ERR_CNT_EN adds a saturating mismatch counter.
module snitch_data_mem_bist #(
    parameter int unsigned TCDMDepth       = 1024,
    parameter int unsigned NarrowDataWidth = 64,
    parameter int unsigned NumTotalBanks   = 32,
    parameter int unsigned AddrWidth       = $clog2(TCDMDepth),
    localparam int unsigned BeWidth        = NarrowDataWidth / 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    input  logic                       abort_i,
    input  logic                       invert_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       fail_o,
    output logic [NumTotalBanks-1:0]   err_banks_o,
    output logic [AddrWidth-1:0]       fail_addr_o,
`ifdef SNITCH_DATA_MEM_BIST_ERR_CNT_EN
    output logic [15:0]                err_cnt_o,
`endif
    input  logic [NumTotalBanks-1:0]   func_cs_i,
    input  logic [AddrWidth-1:0]       func_add_i [NumTotalBanks],
    input  logic [NumTotalBanks-1:0]   func_wen_i,
    input  logic [BeWidth-1:0]         func_be_i [NumTotalBanks],
    input  logic [NarrowDataWidth-1:0] func_wdata_i [NumTotalBanks],
    output logic [NarrowDataWidth-1:0] func_rdata_o [NumTotalBanks],
    output logic [NumTotalBanks-1:0]   mem_cs_o,
    output logic [AddrWidth-1:0]       mem_add_o [NumTotalBanks],
    output logic [NumTotalBanks-1:0]   mem_wen_o,
    output logic [BeWidth-1:0]         mem_be_o [NumTotalBanks],
    output logic [NarrowDataWidth-1:0] mem_wdata_o [NumTotalBanks],
    input  logic [NarrowDataWidth-1:0] mem_rdata_i [NumTotalBanks]
);

    localparam int unsigned Reps = NarrowDataWidth / 32;
    localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(TCDMDepth - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_CHECK,
        S_DONE
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [AddrWidth-1:0]       r_cnt;
    logic                       r_inv;
    logic                       r_done;
    logic [NumTotalBanks-1:0]   r_err;
    logic [AddrWidth-1:0]       r_fail_addr;
    logic                       r_rd_valid;
    logic [AddrWidth-1:0]       r_rd_addr;
    logic                       w_start;
    logic                       w_busy;
    logic                       w_last;
    logic [NumTotalBanks-1:0]   w_mis;

    function automatic logic [NarrowDataWidth-1:0] f_pattern(
        input logic [7:0]           bank,
        input logic [AddrWidth-1:0] addr,
        input logic                 inv
    );
        logic [15:0] a16;
        logic [31:0] w;
        a16 = '0;
        a16[AddrWidth-1:0] = addr;
        w = {bank, 8'h5A, a16} ^ {32{inv}};
        return {Reps{w}};
    endfunction

    assign w_busy  = (r_state == S_WRITE) || (r_state == S_READ) ||
                     (r_state == S_CHECK);
    assign w_start = !w_busy && start_i;
    assign w_last  = (r_cnt == LastAddr);

    assign busy_o       = w_busy;
    assign done_o       = r_done;
    assign err_banks_o  = r_err;
    assign fail_o       = |r_err;
    assign fail_addr_o  = r_fail_addr;
    assign func_rdata_o = mem_rdata_i;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (start_i) w_state_nxt = S_WRITE;
            S_WRITE: begin
                if (abort_i)     w_state_nxt = S_IDLE;
                else if (w_last) w_state_nxt = S_READ;
            end
            S_READ: begin
                if (abort_i)     w_state_nxt = S_IDLE;
                else if (w_last) w_state_nxt = S_CHECK;
            end
            S_CHECK: w_state_nxt = abort_i ? S_IDLE : S_DONE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Functional port is forwarded unless the test owns the array.
    always_comb begin
        mem_cs_o  = func_cs_i;
        mem_wen_o = func_wen_i;
        for (int b = 0; b < NumTotalBanks; b++) begin
            mem_add_o[b]   = func_add_i[b];
            mem_be_o[b]    = func_be_i[b];
            mem_wdata_o[b] = func_wdata_i[b];
        end
        case (r_state)
            S_WRITE: begin
                mem_cs_o  = '1;
                mem_wen_o = '1;
                for (int b = 0; b < NumTotalBanks; b++) begin
                    mem_add_o[b]   = r_cnt;
                    mem_be_o[b]    = '1;
                    mem_wdata_o[b] = f_pattern(8'(b), r_cnt, r_inv);
                end
            end
            S_READ: begin
                mem_cs_o  = '1;
                mem_wen_o = '0;
                for (int b = 0; b < NumTotalBanks; b++) begin
                    mem_add_o[b]   = r_cnt;
                    mem_be_o[b]    = '0;
                    mem_wdata_o[b] = '0;
                end
            end
            S_CHECK: begin
                mem_cs_o  = '0;
                mem_wen_o = '0;
                for (int b = 0; b < NumTotalBanks; b++) begin
                    mem_add_o[b]   = '0;
                    mem_be_o[b]    = '0;
                    mem_wdata_o[b] = '0;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        w_mis = '0;
        for (int b = 0; b < NumTotalBanks; b++) begin
            if (r_rd_valid &&
                mem_rdata_i[b] != f_pattern(8'(b), r_rd_addr, r_inv))
                w_mis[b] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_inv       <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= '0;
            r_fail_addr <= '0;
            r_rd_valid  <= 1'b0;
            r_rd_addr   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            // A read issued in an aborted cycle is never compared.
            r_rd_valid <= (r_state == S_READ) && !abort_i;
            r_rd_addr  <= r_cnt;
            if (w_start) begin
                r_cnt       <= '0;
                r_inv       <= invert_i;
                r_done      <= 1'b0;
                r_err       <= '0;
                r_fail_addr <= '0;
            end else begin
                if (w_busy && abort_i)
                    r_cnt <= '0;
                else if (r_state == S_WRITE || r_state == S_READ)
                    r_cnt <= w_last ? '0 : r_cnt + AddrWidth'(1);
                if (r_state == S_CHECK && !abort_i)
                    r_done <= 1'b1;
                r_err <= r_err | w_mis;
                if (|w_mis && r_err == '0)
                    r_fail_addr <= r_rd_addr;
            end
        end
    end

`ifdef SNITCH_DATA_MEM_BIST_ERR_CNT_EN
    logic [15:0] r_err_cnt;
    logic [16:0] w_nfail;
    logic [16:0] w_cnt_sum;

    always_comb begin
        w_nfail = '0;
        for (int b = 0; b < NumTotalBanks; b++)
            w_nfail = w_nfail + 17'(w_mis[b]);
        w_cnt_sum = {1'b0, r_err_cnt} + w_nfail;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            r_err_cnt <= '0;
        else if (w_start)
            r_err_cnt <= '0;
        else
            r_err_cnt <= w_cnt_sum[16] ? 16'hFFFF : w_cnt_sum[15:0];
    end

    assign err_cnt_o = r_err_cnt;
`endif

endmodule

// File: tb/tb_snitch_data_mem_bist.sv
// Bench for snitch_data_mem_bist: bank-array model, phase-level reference
// model, per-cycle compare plus fixed-value checks on a D=4 / 2-bank array.
module tb_snitch_data_mem_bist;

    localparam int D  = 4;
    localparam int NB = 2;
    localparam int DW = 64;
    localparam int AW = 2;
    localparam int BW = 8;

    logic clk = 1'b0;
    logic rst_i;
    logic start_i, abort_i, invert_i;
    logic busy_o, done_o, fail_o;
    logic [NB-1:0] err_banks_o;
    logic [AW-1:0] fail_addr_o;
`ifdef SNITCH_DATA_MEM_BIST_ERR_CNT_EN
    logic [15:0] err_cnt_o;
`endif
    logic [NB-1:0] func_cs_i, func_wen_i;
    logic [AW-1:0] func_add_i [NB];
    logic [BW-1:0] func_be_i [NB];
    logic [DW-1:0] func_wdata_i [NB];
    logic [DW-1:0] func_rdata_o [NB];
    logic [NB-1:0] mem_cs_o, mem_wen_o;
    logic [AW-1:0] mem_add_o [NB];
    logic [BW-1:0] mem_be_o [NB];
    logic [DW-1:0] mem_wdata_o [NB];
    logic [DW-1:0] mem_rdata_i [NB];

    always #5 clk = ~clk;

    snitch_data_mem_bist #(
        .TCDMDepth(D), .NarrowDataWidth(DW), .NumTotalBanks(NB)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
        .abort_i(abort_i), .invert_i(invert_i),
        .busy_o(busy_o), .done_o(done_o), .fail_o(fail_o),
        .err_banks_o(err_banks_o), .fail_addr_o(fail_addr_o),
`ifdef SNITCH_DATA_MEM_BIST_ERR_CNT_EN
        .err_cnt_o(err_cnt_o),
`endif
        .func_cs_i(func_cs_i), .func_add_i(func_add_i),
        .func_wen_i(func_wen_i), .func_be_i(func_be_i),
        .func_wdata_i(func_wdata_i), .func_rdata_o(func_rdata_o),
        .mem_cs_o(mem_cs_o), .mem_add_o(mem_add_o),
        .mem_wen_o(mem_wen_o), .mem_be_o(mem_be_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] pat(input int b, input int a,
                                        input bit inv);
        logic [31:0] w;
        logic [7:0]  bb;
        logic [15:0] aa;
        bb = b[7:0];
        aa = a[15:0];
        w = {bb, 8'h5A, aa};
        if (inv) w = ~w;
        return {w, w};
    endfunction

    // Bank array with one optional stuck-at bit applied on write.
    logic [DW-1:0] tmem [NB][D];
    bit f_en;
    int f_b, f_a, f_bit;
    bit f_val;

    initial begin
        for (int b = 0; b < NB; b++) begin
            mem_rdata_i[b] = '0;
            for (int a = 0; a < D; a++) tmem[b][a] = '0;
        end
        forever begin
            @(posedge clk);
            for (int b = 0; b < NB; b++) begin
                if (mem_cs_o[b] === 1'b1) begin
                    if (mem_wen_o[b]) begin
                        logic [DW-1:0] v;
                        v = tmem[b][mem_add_o[b]];
                        for (int i = 0; i < BW; i++)
                            if (mem_be_o[b][i])
                                v[8*i+:8] = mem_wdata_o[b][8*i+:8];
                        if (f_en && b == f_b && int'(mem_add_o[b]) == f_a)
                            v[f_bit] = f_val;
                        tmem[b][mem_add_o[b]] <= v;
                    end else begin
                        mem_rdata_i[b] <= tmem[b][mem_add_o[b]];
                    end
                end
            end
        end
    end

    // Reference: ph 0 idle, 1 running (k = cycle index since start), 2 done.
    int m_ph = 0, m_k = 0, m_fa = 0, m_cnt = 0;
    bit m_inv = 0, m_done = 0;
    logic [NB-1:0] m_err = '0;

    initial forever begin
        @(posedge clk or posedge rst_i);
        if (rst_i) begin
            m_ph = 0; m_k = 0; m_fa = 0; m_cnt = 0;
            m_inv = 0; m_done = 0; m_err = '0;
        end else begin
            if (m_ph == 1 && m_k >= D + 2 && m_k <= 2 * D + 1) begin
                int a, n;
                logic [NB-1:0] mis;
                a = m_k - D - 2;
                n = 0;
                mis = '0;
                for (int b = 0; b < NB; b++)
                    if (tmem[b][a] !== pat(b, a, m_inv)) begin
                        mis[b] = 1'b1;
                        n++;
                    end
                if (m_err == '0 && mis != '0) m_fa = a;
                m_err = m_err | mis;
                m_cnt = (m_cnt + n > 65535) ? 65535 : m_cnt + n;
            end
            if (m_ph != 1) begin
                if (start_i) begin
                    m_ph = 1; m_k = 1; m_inv = invert_i;
                    m_done = 0; m_err = '0; m_fa = 0; m_cnt = 0;
                end
            end else if (abort_i) begin
                m_ph = 0;
            end else if (m_k == 2 * D + 1) begin
                m_ph = 2;
                m_done = 1;
            end else begin
                m_k++;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        chk("busy", busy_o, m_ph == 1);
        chk("done", done_o, m_done);
        chk("err_banks", err_banks_o, m_err);
        chk("fail", fail_o, m_err != '0);
        chk("fail_addr", fail_addr_o, m_fa);
`ifdef SNITCH_DATA_MEM_BIST_ERR_CNT_EN
        chk("err_cnt", err_cnt_o, m_cnt);
`endif
        for (int b = 0; b < NB; b++) begin
            chk("func_rdata", func_rdata_o[b], mem_rdata_i[b]);
            if (m_ph != 1) begin
                chk("pass_cs", mem_cs_o[b], func_cs_i[b]);
                chk("pass_wen", mem_wen_o[b], func_wen_i[b]);
                chk("pass_add", mem_add_o[b], func_add_i[b]);
                chk("pass_be", mem_be_o[b], func_be_i[b]);
                chk("pass_wdata", mem_wdata_o[b], func_wdata_i[b]);
            end else if (m_k <= D) begin
                chk("wr_cs", mem_cs_o[b], 1);
                chk("wr_wen", mem_wen_o[b], 1);
                chk("wr_add", mem_add_o[b], m_k - 1);
                chk("wr_be", mem_be_o[b], 8'hFF);
                chk("wr_wdata", mem_wdata_o[b], pat(b, m_k - 1, m_inv));
            end else if (m_k <= 2 * D) begin
                chk("rd_cs", mem_cs_o[b], 1);
                chk("rd_wen", mem_wen_o[b], 0);
                chk("rd_add", mem_add_o[b], m_k - D - 1);
                chk("rd_be", mem_be_o[b], 0);
                chk("rd_wdata", mem_wdata_o[b], 0);
            end else begin
                chk("chk_cs", mem_cs_o[b], 0);
            end
        end
    end

    bit rnd_func = 1;

    task automatic cyc();
        @(posedge clk);
        #1;
        if (rnd_func) begin
            func_cs_i  = NB'($urandom);
            func_wen_i = NB'($urandom);
            for (int b = 0; b < NB; b++) begin
                func_add_i[b]   = AW'($urandom);
                func_be_i[b]    = BW'($urandom);
                func_wdata_i[b] = {$urandom, $urandom};
            end
        end
    endtask

    // Leaves the bench in cycle 1 of the run.
    task automatic start_run(input bit inv);
        start_i  = 1'b1;
        invert_i = inv;
        cyc();
        start_i  = 1'b0;
        invert_i = 1'b0;
    endtask

    task automatic to_cycle(input int from, input int to);
        for (int c = from; c < to; c++) cyc();
    endtask

    initial begin
        rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0; invert_i = 1'b0;
        func_cs_i = '0; func_wen_i = '0;
        for (int b = 0; b < NB; b++) begin
            func_add_i[b] = '0; func_be_i[b] = '0; func_wdata_i[b] = '0;
        end
        f_en = 0; f_b = 0; f_a = 0; f_bit = 0; f_val = 0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_err", err_banks_o, 0);
        chk("rst_fail_addr", fail_addr_o, 0);
        rst_i = 1'b0;

        rnd_func = 0;
        cyc();
        func_cs_i = 2'b01; func_wen_i = 2'b01;
        func_add_i[0] = 2'd3; func_be_i[0] = 8'h0F;
        func_wdata_i[0] = 64'h1234_5678_9ABC_DEF0;
        #1;
        chk("idle_cs", mem_cs_o, 2'b01);
        chk("idle_add0", mem_add_o[0], 3);
        chk("idle_wen", mem_wen_o, 2'b01);
        chk("idle_wdata0", mem_wdata_o[0], 64'h1234_5678_9ABC_DEF0);
        chk("idle_busy", busy_o, 0);
        rnd_func = 1;

        start_run(0);
        to_cycle(1, 3);
        #1;
        chk("t1_add1", mem_add_o[1], 2);
        chk("t1_wdata1", mem_wdata_o[1], 64'h015A0002_015A0002);
        to_cycle(3, 9);
        #1;
        chk("t1_done9", done_o, 0);
        to_cycle(9, 10);
        #1;
        chk("t1_done10", done_o, 1);
        chk("t1_err", err_banks_o, 2'b00);
        chk("t1_fail", fail_o, 0);

        f_en = 1; f_b = 1; f_a = 2; f_bit = 1; f_val = 0;
        start_run(0);
        to_cycle(1, 10);
        #1;
        chk("t2_done", done_o, 1);
        chk("t2_err", err_banks_o, 2'b10);
        chk("t2_fail_addr", fail_addr_o, 2);
        chk("t2_fail", fail_o, 1);
`ifdef SNITCH_DATA_MEM_BIST_ERR_CNT_EN
        chk("t2_cnt", err_cnt_o, 1);
`endif
        f_en = 0;

        start_run(1);
        to_cycle(1, 2);
        #1;
        chk("t3_wdata0", mem_wdata_o[0], 64'hFFA5FFFE_FFA5FFFE);
        to_cycle(2, 10);
        #1;
        chk("t3_done", done_o, 1);
        chk("t3_err", err_banks_o, 2'b00);

        start_run(0);
        to_cycle(1, 6);
        abort_i = 1'b1;
        rnd_func = 0;
        func_cs_i = '0;
        cyc();
        abort_i = 1'b0;
        #1;
        chk("t5_cs", mem_cs_o, 2'b00);
        chk("t5_busy", busy_o, 0);
        chk("t5_done", done_o, 0);
        rnd_func = 1;
        start_run(0);
        to_cycle(1, 10);
        #1;
        chk("t5_rerun_done", done_o, 1);

        start_run(0);
        to_cycle(1, 3);
        rst_i = 1'b1;
        #1;
        chk("t6_busy", busy_o, 0);
        chk("t6_done", done_o, 0);
        chk("t6_err", err_banks_o, 0);
        chk("t6_fail_addr", fail_addr_o, 0);
        chk("t6_cs", mem_cs_o, func_cs_i);
        cyc();
        rst_i = 1'b0;
        start_run(0);
        to_cycle(1, 10);
        #1;
        chk("t6_rerun_done", done_o, 1);
        chk("t6_rerun_err", err_banks_o, 0);

        for (int it = 0; it < 40; it++) begin
            int ab;
            f_en  = ($urandom % 2) == 1;
            f_b   = $urandom_range(0, NB - 1);
            f_a   = $urandom_range(0, D - 1);
            f_bit = $urandom_range(0, DW - 1);
            f_val = ($urandom % 2) == 1;
            ab = ($urandom % 3 == 0) ? $urandom_range(1, 2 * D + 1) : 0;
            start_run(($urandom % 2) == 1);
            for (int k = 1; k <= 2 * D + 1; k++) begin
                if (k == ab) begin
                    abort_i = 1'b1;
                    cyc();
                    abort_i = 1'b0;
                    break;
                end
                start_i = ($urandom % 4) == 0;
                cyc();
                start_i = 1'b0;
            end
            repeat ($urandom_range(0, 3)) cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
